// File: rtl/trap_controller_if.sv
// Trap controller shared types and port bundle.
// EX/CSR side inputs and redirect/flush outputs.
package riscv_pkg;
    typedef struct packed {
        logic meip;
        logic mtip;
        logic msip;
    } interrupt_t;
endpackage

interface trap_controller_if #(
    parameter int XLEN          = 32,
    parameter int NUM_LOCAL_IRQ = 16
) ();
    import riscv_pkg::*;

    logic                     i_pipeline_stall;
    logic                     i_mstatus_mie;
    logic [XLEN-1:0]          i_mie;
    logic [XLEN-1:0]          i_mtvec;
    logic [XLEN-1:0]          i_mepc;
    interrupt_t               i_interrupts;
    logic [NUM_LOCAL_IRQ-1:0] i_irq_local;
    logic                     i_exception_valid;
    logic [XLEN-1:0]          i_exception_cause;
    logic [XLEN-1:0]          i_exception_tval;
    logic [XLEN-1:0]          i_exception_pc;
    logic                     i_mret_in_ex;
    logic                     i_wfi_in_ex;
    logic                     o_trap_taken;
    logic                     o_mret_taken;
    logic [XLEN-1:0]          o_trap_target;
    logic [XLEN-1:0]          o_trap_pc;
    logic [XLEN-1:0]          o_trap_cause;
    logic [XLEN-1:0]          o_trap_value;
    logic                     o_flush;
    logic                     o_stall_for_wfi;

    modport slave (
        input  i_pipeline_stall, i_mstatus_mie, i_mie, i_mtvec, i_mepc,
        input  i_interrupts, i_irq_local,
        input  i_exception_valid, i_exception_cause, i_exception_tval,
        input  i_exception_pc, i_mret_in_ex, i_wfi_in_ex,
        output o_trap_taken, o_mret_taken, o_trap_target, o_trap_pc,
        output o_trap_cause, o_trap_value, o_flush, o_stall_for_wfi
    );

    modport master (
        output i_pipeline_stall, i_mstatus_mie, i_mie, i_mtvec, i_mepc,
        output i_interrupts, i_irq_local,
        output i_exception_valid, i_exception_cause, i_exception_tval,
        output i_exception_pc, i_mret_in_ex, i_wfi_in_ex,
        input  o_trap_taken, o_mret_taken, o_trap_target, o_trap_pc,
        input  o_trap_cause, o_trap_value, o_flush, o_stall_for_wfi
    );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap controller: interrupt arbitration,
// exception/MRET redirect, WFI stall and flush window.
module trap_controller #(
    parameter int XLEN          = 32,
    parameter int NUM_LOCAL_IRQ = 16,
    parameter int FLUSH_CYCLES  = 2
) (
    input  logic           i_clk,
    input  logic           i_rst,
    trap_controller_if.slave bus
);
    import riscv_pkg::*;

    typedef enum logic [1:0] {IDLE, FLUSH, WFI} state_t;

    state_t          state_q;
    logic [2:0]      cnt_q;
    logic            int_pending_q;
    logic [XLEN-1:0] int_cause_q;
    logic [6:0]      int_offset_q;
    logic            stall_q;

    logic [XLEN-1:0] pend;
    logic [XLEN-1:0] en;
    logic [4:0]      code;
    logic            wake;
    logic            take_trap;
    logic            take_mret;
    logic            go_wfi;
    logic [XLEN-1:0] base;

    // Pending vector and enabled/arbitrated winner (lowest local wins).
    always_comb begin
        pend = '0;
        pend[3]  = bus.i_interrupts.msip;
        pend[7]  = bus.i_interrupts.mtip;
        pend[11] = bus.i_interrupts.meip;
        for (int k = 0; k < NUM_LOCAL_IRQ; k++) begin
            pend[16+k] = bus.i_irq_local[k];
        end
        en = pend & bus.i_mie & {XLEN{bus.i_mstatus_mie}};
        if (state_q != IDLE) en = '0;
        code = 5'd0;
        for (int i = XLEN-1; i >= 16; i--) begin
            if (en[i]) code = 5'(i);
        end
        if (en[7])  code = 5'd7;
        if (en[3])  code = 5'd3;
        if (en[11]) code = 5'd11;
        wake = |(pend & bus.i_mie);
    end

    assign take_trap = (int_pending_q | bus.i_exception_valid)
                     & !bus.i_pipeline_stall & (state_q == IDLE);
    assign take_mret = bus.i_mret_in_ex & !bus.i_pipeline_stall
                     & !take_trap & (state_q == IDLE);
    assign go_wfi    = bus.i_wfi_in_ex & !bus.i_pipeline_stall
                     & !take_trap;
    assign base      = {bus.i_mtvec[XLEN-1:2], 2'b00};

    // Trap record and redirect target selection.
    always_comb begin
        bus.o_trap_taken = take_trap;
        bus.o_mret_taken = take_mret;
        bus.o_flush      = (state_q == FLUSH);
        bus.o_stall_for_wfi = stall_q;
        bus.o_trap_pc    = bus.i_exception_pc;
        if (int_pending_q) begin
            bus.o_trap_cause = int_cause_q;
            bus.o_trap_value = '0;
        end else begin
            bus.o_trap_cause = bus.i_exception_cause;
            bus.o_trap_value = bus.i_exception_tval;
        end
        bus.o_trap_target = '0;
        if (take_mret) begin
            bus.o_trap_target = bus.i_mepc;
        end else if (take_trap) begin
            if (bus.i_mtvec[1:0] == 2'b01 && int_pending_q)
                bus.o_trap_target = base + XLEN'(int_offset_q);
            else
                bus.o_trap_target = base;
        end
    end

    // Controller FSM, interrupt winner register and WFI stall.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            int_pending_q <= 1'b0;
            int_cause_q   <= '0;
            int_offset_q  <= '0;
            stall_q       <= 1'b0;
        end else begin
            int_pending_q <= |en;
            int_cause_q   <= {1'b1, {(XLEN-6){1'b0}}, code};
            int_offset_q  <= {code, 2'b00};
            stall_q       <= (state_q == WFI) & !wake;
            unique case (state_q)
                IDLE: begin
                    if (take_trap | take_mret) begin
                        state_q <= FLUSH;
                        cnt_q   <= 3'(FLUSH_CYCLES-1);
                    end else if (go_wfi) begin
                        state_q <= WFI;
                    end
                end
                FLUSH: begin
                    if (cnt_q == 3'd0) state_q <= IDLE;
                    else               cnt_q   <= cnt_q - 3'd1;
                end
                WFI: begin
                    if (wake) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller.
// Second instance exercises a 4-cycle flush window.
module tb_trap_controller;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int   checks = 0;
    int   errors = 0;

    trap_controller_if #(.XLEN(32), .NUM_LOCAL_IRQ(16)) a ();
    trap_controller_if #(.XLEN(32), .NUM_LOCAL_IRQ(16)) b ();

    assign b.i_pipeline_stall  = a.i_pipeline_stall;
    assign b.i_mstatus_mie     = a.i_mstatus_mie;
    assign b.i_mie             = a.i_mie;
    assign b.i_mtvec           = a.i_mtvec;
    assign b.i_mepc            = a.i_mepc;
    assign b.i_interrupts      = a.i_interrupts;
    assign b.i_irq_local       = a.i_irq_local;
    assign b.i_exception_valid = a.i_exception_valid;
    assign b.i_exception_cause = a.i_exception_cause;
    assign b.i_exception_tval  = a.i_exception_tval;
    assign b.i_exception_pc    = a.i_exception_pc;
    assign b.i_mret_in_ex      = a.i_mret_in_ex;
    assign b.i_wfi_in_ex       = a.i_wfi_in_ex;

    trap_controller #(.XLEN(32), .NUM_LOCAL_IRQ(16), .FLUSH_CYCLES(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (a)
    );

    trap_controller #(.XLEN(32), .NUM_LOCAL_IRQ(16), .FLUSH_CYCLES(4)) dut4 (
        .i_clk (clk),
        .i_rst (rst2),
        .bus   (b)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic await_trap(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!a.o_trap_taken && n < 12);
        chk(tag, 32'(a.o_trap_taken), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        a.i_pipeline_stall  = 0;
        a.i_mstatus_mie     = 0;
        a.i_mie             = '0;
        a.i_mtvec           = '0;
        a.i_mepc            = '0;
        a.i_interrupts      = '0;
        a.i_irq_local       = '0;
        a.i_exception_valid = 0;
        a.i_exception_cause = '0;
        a.i_exception_tval  = '0;
        a.i_exception_pc    = 32'h4000;
        a.i_mret_in_ex      = 0;
        a.i_wfi_in_ex       = 0;
        step();
        step();
        chk("rst_trap", 32'(a.o_trap_taken), 0);
        chk("rst_mret", 32'(a.o_mret_taken), 0);
        chk("rst_flush", 32'(a.o_flush), 0);
        chk("rst_target", a.o_trap_target, 0);
        chk("rst_stall", 32'(a.o_stall_for_wfi), 0);
        rst  = 1'b0;
        rst2 = 1'b0;

        // vectored timer trap
        a.i_mtvec       = 32'h101;
        a.i_mie         = 32'h80;
        a.i_mstatus_mie = 1;
        a.i_interrupts.mtip = 1;
        step();
        chk("tmr_taken", 32'(a.o_trap_taken), 1);
        chk("tmr_target", a.o_trap_target, 32'h11C);
        chk("tmr_cause", a.o_trap_cause, 32'h80000007);
        chk("tmr_value", a.o_trap_value, 0);
        chk("tmr_pc", a.o_trap_pc, 32'h4000);
        chk("tmr_flush0", 32'(a.o_flush), 0);
        step();
        chk("tmr_flush1", 32'(a.o_flush), 1);
        chk("tmr_noretrap1", 32'(a.o_trap_taken), 0);
        step();
        chk("tmr_flush2", 32'(a.o_flush), 1);
        chk("tmr_noretrap2", 32'(a.o_trap_taken), 0);
        step();
        chk("tmr_flush3", 32'(a.o_flush), 0);
        chk("tmr_noretrap3", 32'(a.o_trap_taken), 0);
        a.i_interrupts.mtip = 0;
        step();
        chk("tmr_quiet", 32'(a.o_trap_taken), 0);

        // priority ladder
        a.i_mie = 32'h0001_0888;
        a.i_interrupts = '{meip: 1'b1, mtip: 1'b0, msip: 1'b1};
        a.i_irq_local  = 16'h0001;
        await_trap("lad_wait1");
        chk("lad_cause1", a.o_trap_cause, 32'h8000000B);
        chk("lad_tgt1", a.o_trap_target, 32'h12C);
        a.i_interrupts.meip = 0;
        await_trap("lad_wait2");
        chk("lad_cause2", a.o_trap_cause, 32'h80000003);
        chk("lad_tgt2", a.o_trap_target, 32'h10C);
        a.i_interrupts.msip = 0;
        await_trap("lad_wait3");
        chk("lad_cause3", a.o_trap_cause, 32'h80000010);
        chk("lad_tgt3", a.o_trap_target, 32'h140);

        // local index priority
        a.i_irq_local = 16'h8004;
        a.i_mie       = 32'h8004_0000;
        await_trap("loc_wait");
        chk("loc_cause", a.o_trap_cause, 32'h80000012);
        chk("loc_tgt", a.o_trap_target, 32'h148);
        a.i_irq_local = '0;
        repeat (4) step();
        chk("loc_idle", 32'(a.o_flush), 0);

        // interrupt beats exception
        a.i_mie = 32'h80;
        a.i_interrupts.mtip = 1;
        step();
        a.i_exception_valid = 1;
        a.i_exception_cause = 32'd2;
        a.i_exception_tval  = 32'hDEAD;
        #1;
        chk("col_taken", 32'(a.o_trap_taken), 1);
        chk("col_cause", a.o_trap_cause, 32'h80000007);
        chk("col_value", a.o_trap_value, 0);
        chk("col_pc", a.o_trap_pc, 32'h4000);
        a.i_interrupts.mtip = 0;
        a.i_exception_valid = 0;
        repeat (4) step();

        // interrupt beats MRET
        a.i_mepc = 32'h8888;
        a.i_interrupts.mtip = 1;
        step();
        a.i_mret_in_ex = 1;
        #1;
        chk("colm_trap", 32'(a.o_trap_taken), 1);
        chk("colm_mret", 32'(a.o_mret_taken), 0);
        chk("colm_tgt", a.o_trap_target, 32'h11C);
        a.i_interrupts.mtip = 0;
        a.i_mret_in_ex = 0;
        repeat (4) step();

        // plain MRET
        a.i_mret_in_ex = 1;
        #1;
        chk("mret_taken", 32'(a.o_mret_taken), 1);
        chk("mret_tgt", a.o_trap_target, 32'h8888);
        step();
        a.i_mret_in_ex = 0;
        chk("mret_flush", 32'(a.o_flush), 1);
        repeat (3) step();

        // WFI with global MIE clear: wake without trap
        a.i_mstatus_mie = 0;
        a.i_mtvec       = 32'h200;
        a.i_mie         = 32'h800;
        a.i_wfi_in_ex   = 1;
        step();
        a.i_wfi_in_ex = 0;
        step();
        chk("wfi0_stall", 32'(a.o_stall_for_wfi), 1);
        step();
        chk("wfi0_hold", 32'(a.o_stall_for_wfi), 1);
        a.i_interrupts.meip = 1;
        step();
        chk("wfi0_release", 32'(a.o_stall_for_wfi), 0);
        chk("wfi0_notrap1", 32'(a.o_trap_taken), 0);
        step();
        chk("wfi0_notrap2", 32'(a.o_trap_taken), 0);
        a.i_interrupts.meip = 0;
        step();

        // WFI with global MIE set: wake then trap
        a.i_mstatus_mie = 1;
        a.i_wfi_in_ex   = 1;
        step();
        a.i_wfi_in_ex = 0;
        step();
        chk("wfi1_stall", 32'(a.o_stall_for_wfi), 1);
        a.i_interrupts.meip = 1;
        step();
        chk("wfi1_release", 32'(a.o_stall_for_wfi), 0);
        chk("wfi1_early", 32'(a.o_trap_taken), 0);
        step();
        chk("wfi1_taken", 32'(a.o_trap_taken), 1);
        chk("wfi1_tgt", a.o_trap_target, 32'h200);
        chk("wfi1_cause", a.o_trap_cause, 32'h8000000B);
        chk("wfi1_pc", a.o_trap_pc, 32'h4000);
        a.i_interrupts.meip = 0;
        repeat (4) step();

        // stall blocks a pending exception
        a.i_pipeline_stall  = 1;
        a.i_exception_valid = 1;
        a.i_exception_cause = 32'd2;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_block", 32'(a.o_trap_taken), 0);
        end
        a.i_pipeline_stall = 0;
        #1;
        chk("stall_taken", 32'(a.o_trap_taken), 1);
        chk("stall_cause", a.o_trap_cause, 32'd2);
        chk("stall_value", a.o_trap_value, 32'hDEAD);
        chk("stall_tgt", a.o_trap_target, 32'h200);
        step();
        a.i_exception_valid = 0;
        repeat (6) step();

        // reset in the middle of a 4-cycle flush
        chk("r4_idle", 32'(b.o_flush), 0);
        a.i_exception_valid = 1;
        #1;
        chk("r4_taken", 32'(b.o_trap_taken), 1);
        step();
        a.i_exception_valid = 0;
        chk("r4_flush3", 32'(b.o_flush), 1);
        step();
        chk("r4_flush2", 32'(b.o_flush), 1);
        rst2 = 1;
        step();
        rst2 = 0;
        chk("r4_cleared", 32'(b.o_flush), 0);
        a.i_exception_valid = 1;
        #1;
        chk("r4_reaccept", 32'(b.o_trap_taken), 1);
        step();
        a.i_exception_valid = 0;
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
